// File: rtl/sobel_pack_pkg.sv
// Shared constants, read-FSM state type and counter-width helper for the
// Sobel-to-UDP line packer.
package sobel_pack_pkg;

  localparam int HDR_BYTES   = 4;
  localparam int FRAME_NUM_W = 16;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_REQ,
    RD_HDR,
    RD_PAY
  } rd_state_t;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sobel_udp_line_packer_if.sv
// Packet handshake towards the UDP TX engine: request/ack grant followed by a
// valid/ready byte stream with an end-of-packet marker.
interface sobel_udp_line_packer_if;

  logic       tx_req;
  logic       tx_ack;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       tx_last;

  modport master (
    output tx_req, tx_valid, tx_data, tx_last,
    input  tx_ack, tx_ready
  );

  modport slave (
    input  tx_req, tx_valid, tx_data, tx_last,
    output tx_ack, tx_ready
  );

endinterface

// File: rtl/line_bank_ram.sv
// Two line banks in one simple dual-port RAM, addressed as {bank, x}, with a
// registered read port that holds its output while re is low.
module line_bank_ram
  import sobel_pack_pkg::*;
#(
  parameter int IMG_WIDTH = 640
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [cnt_w(IMG_WIDTH):0]    waddr,
  input  logic [7:0]                   wdata,
  input  logic                         re,
  input  logic [cnt_w(IMG_WIDTH):0]    raddr,
  output logic [7:0]                   rdata
);

  localparam int AW = cnt_w(IMG_WIDTH) + 1;

  logic [7:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sobel_udp_line_packer.sv
// Buffers Sobel pixel lines into ping-pong banks and sends each full line as a
// UDP payload (4-byte header + pixels). Option: LINE_PACKER_CHECKSUM_EN.
module sobel_udp_line_packer
  import sobel_pack_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pix_valid,
  input  logic [7:0]              pix_data,
  input  logic                    frame_sync,
  sobel_udp_line_packer_if.master tx,
  output logic [7:0]              drop_cnt
);

  localparam int XW = cnt_w(IMG_WIDTH);
  localparam int YW = cnt_w(IMG_HEIGHT);
`ifdef LINE_PACKER_CHECKSUM_EN
  localparam int PKT_BYTES = HDR_BYTES + IMG_WIDTH + 1;
`else
  localparam int PKT_BYTES = HDR_BYTES + IMG_WIDTH;
`endif
  localparam int IW = cnt_w(PKT_BYTES + 1);

  logic [XW-1:0]          x_cnt, eff_x;
  logic [YW-1:0]          y_cnt, eff_y;
  logic [FRAME_NUM_W-1:0] frame_num, eff_frame;
  logic                   wr_bank, rd_bank, dropping;
  logic [1:0]             bank_full;
  logic [15:0]            tag_frame [2];
  logic [15:0]            tag_line  [2];
  logic                   line_start, line_end, drop_now, wr_en, line_done;

  rd_state_t              state, state_next;
  logic [IW-1:0]          idx, nidx;
  logic                   load, xfer, bank_free, next_is_pay, next_last;
  logic [7:0]             next_byte, ram_rdata;
  logic                   ram_re;
  logic [XW-1:0]          ram_rx;
  logic [15:0]            hdr_frame, hdr_line;
`ifdef LINE_PACKER_CHECKSUM_EN
  logic [7:0]             csum;
`endif

  // A frame_sync pixel is pixel (0,0) of the next frame, so resolve position first.
  always_comb begin
    eff_x      = frame_sync ? '0 : x_cnt;
    eff_y      = frame_sync ? '0 : y_cnt;
    eff_frame  = (frame_sync && (x_cnt != '0 || y_cnt != '0)) ? frame_num + 16'd1 : frame_num;
    line_start = (eff_x == '0);
    line_end   = (eff_x == XW'(IMG_WIDTH - 1));
    drop_now   = line_start ? bank_full[wr_bank] : dropping;
    wr_en      = pix_valid && !drop_now;
    line_done  = wr_en && line_end;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_cnt     <= '0;
      y_cnt     <= '0;
      frame_num <= '0;
      wr_bank   <= 1'b0;
      dropping  <= 1'b0;
      drop_cnt  <= '0;
      bank_full <= '0;
      for (int b = 0; b < 2; b++) begin
        tag_frame[b] <= '0;
        tag_line[b]  <= '0;
      end
    end else begin
      if (bank_free) bank_full[rd_bank] <= 1'b0;
      if (pix_valid) begin
        dropping <= drop_now;
        if (line_start && drop_now && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        if (line_end) begin
          x_cnt <= '0;
          if (eff_y == YW'(IMG_HEIGHT - 1)) begin
            y_cnt     <= '0;
            frame_num <= eff_frame + 16'd1;
          end else begin
            y_cnt     <= eff_y + YW'(1);
            frame_num <= eff_frame;
          end
        end else begin
          x_cnt     <= eff_x + XW'(1);
          y_cnt     <= eff_y;
          frame_num <= eff_frame;
        end
        if (line_done) begin
          bank_full[wr_bank] <= 1'b1;
          tag_frame[wr_bank] <= eff_frame;
          tag_line[wr_bank]  <= 16'(eff_y);
          wr_bank            <= ~wr_bank;
        end
      end else if (frame_sync) begin
        x_cnt     <= '0;
        y_cnt     <= '0;
        frame_num <= eff_frame;
      end
    end
  end

  line_bank_ram #(.IMG_WIDTH(IMG_WIDTH)) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr ({wr_bank, eff_x}),
    .wdata (pix_data),
    .re    (ram_re),
    .raddr ({rd_bank, ram_rx}),
    .rdata (ram_rdata)
  );

  assign xfer      = tx.tx_valid && tx.tx_ready;
  assign bank_free = xfer && tx.tx_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RD_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    tx.tx_req  = 1'b0;
    load       = 1'b0;
    nidx       = idx + IW'(1);
    case (state)
      RD_IDLE: if (bank_full[rd_bank]) state_next = RD_REQ;
      RD_REQ: begin
        tx.tx_req = 1'b1;
        if (tx.tx_ack) begin
          state_next = RD_HDR;
          load       = 1'b1;
          nidx       = '0;
        end
      end
      RD_HDR: if (xfer) begin
        load = 1'b1;
        if (nidx == IW'(HDR_BYTES)) state_next = RD_PAY;
      end
      RD_PAY: if (xfer) begin
        if (tx.tx_last) state_next = RD_IDLE;
        else            load       = 1'b1;
      end
      default: state_next = RD_IDLE;
    endcase
  end

  // RAM is read one byte ahead of the output register; pixel 0 is fetched at grant.
  always_comb begin
    hdr_frame   = tag_frame[rd_bank];
    hdr_line    = tag_line[rd_bank];
    next_is_pay = (nidx >= IW'(HDR_BYTES)) && (nidx < IW'(HDR_BYTES + IMG_WIDTH));
    next_last   = (nidx == IW'(PKT_BYTES - 1));
    next_byte   = ram_rdata;
`ifdef LINE_PACKER_CHECKSUM_EN
    if (nidx == IW'(PKT_BYTES - 1)) next_byte = csum;
`endif
    if (nidx == IW'(0)) next_byte = hdr_frame[15:8];
    if (nidx == IW'(1)) next_byte = hdr_frame[7:0];
    if (nidx == IW'(2)) next_byte = hdr_line[15:8];
    if (nidx == IW'(3)) next_byte = hdr_line[7:0];
    ram_re = 1'b0;
    ram_rx = '0;
    if (load && nidx == IW'(0)) begin
      ram_re = 1'b1;
    end else if (load && next_is_pay && nidx != IW'(HDR_BYTES + IMG_WIDTH - 1)) begin
      ram_re = 1'b1;
      ram_rx = XW'(nidx - IW'(HDR_BYTES - 1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx.tx_valid <= 1'b0;
      tx.tx_data  <= '0;
      tx.tx_last  <= 1'b0;
      idx         <= '0;
      rd_bank     <= 1'b0;
`ifdef LINE_PACKER_CHECKSUM_EN
      csum        <= '0;
`endif
    end else if (load) begin
      tx.tx_valid <= 1'b1;
      tx.tx_data  <= next_byte;
      tx.tx_last  <= next_last;
      idx         <= nidx;
`ifdef LINE_PACKER_CHECKSUM_EN
      if (nidx == IW'(0))    csum <= '0;
      else if (next_is_pay)  csum <= csum ^ ram_rdata;
`endif
    end else if (bank_free) begin
      tx.tx_valid <= 1'b0;
      tx.tx_last  <= 1'b0;
      rd_bank     <= ~rd_bank;
    end
  end

endmodule

// File: tb/tb_sobel_udp_line_packer.sv
// Randomized self-checking bench for sobel_udp_line_packer (8x4 image) with a
// pixel-index based packet model; honours LINE_PACKER_CHECKSUM_EN.
module tb_sobel_udp_line_packer;

  localparam int W = 8;
  localparam int H = 4;
`ifdef LINE_PACKER_CHECKSUM_EN
  localparam int PKT = W + 5;
`else
  localparam int PKT = W + 4;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pix_valid = 1'b0;
  logic [7:0] pix_data = 8'h00;
  logic       frame_sync = 1'b0;
  logic [7:0] drop_cnt;

  sobel_udp_line_packer_if tx_if ();

  sobel_udp_line_packer #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .frame_sync (frame_sync),
    .tx         (tx_if),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: linear pixel index within the frame, plus buffered-line occupancy.
  int         m_frame, m_pix, m_pending, m_drops;
  bit         m_dropping;
  logic [7:0] cur_line [W];
  logic [7:0] exp_q [$];

  function automatic void model_reset();
    m_frame = 0; m_pix = 0; m_pending = 0; m_drops = 0; m_dropping = 0;
    exp_q.delete();
  endfunction

  function automatic void model_sync();
    if (m_pix != 0) m_frame = (m_frame + 1) % 65536;
    m_pix = 0;
  endfunction

  function automatic void model_pixel(input logic [7:0] d, input bit s);
    int x, y;
    logic [7:0] cs;
    if (s) model_sync();
    x = m_pix % W;
    y = m_pix / W;
    if (x == 0) begin
      m_dropping = (m_pending >= 2);
      if (m_dropping && m_drops < 255) m_drops++;
    end
    if (!m_dropping) cur_line[x] = d;
    if (x == W - 1 && !m_dropping) begin
      exp_q.push_back(8'(m_frame >> 8));
      exp_q.push_back(8'(m_frame));
      exp_q.push_back(8'(y >> 8));
      exp_q.push_back(8'(y));
      cs = 8'h00;
      for (int i = 0; i < W; i++) begin
        exp_q.push_back(cur_line[i]);
        cs = cs ^ cur_line[i];
      end
`ifdef LINE_PACKER_CHECKSUM_EN
      exp_q.push_back(cs);
`endif
      m_pending++;
    end
    m_pix++;
    if (m_pix == W * H) begin
      m_pix = 0;
      m_frame = (m_frame + 1) % 65536;
    end
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; pix_valid = 1'b0; frame_sync = 1'b0;
    tx_if.tx_ack = 1'b0; tx_if.tx_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic send_pixel(input logic [7:0] d, input bit s);
    @(negedge clk);
    pix_valid = 1'b1; pix_data = d; frame_sync = s;
    model_pixel(d, s);
  endtask

  task automatic end_stream();
    @(negedge clk);
    pix_valid = 1'b0; frame_sync = 1'b0; pix_data = 8'h00;
  endtask

  task automatic send_line(input bit rnd, input logic [7:0] base);
    for (int i = 0; i < W; i++) send_pixel(rnd ? 8'($urandom) : base + 8'(i), 1'b0);
  endtask

  task automatic wait_req(output bit ok);
    ok = 0;
    for (int i = 0; i < 64; i++) begin
      if (tx_if.tx_req === 1'b1) begin ok = 1; break; end
      @(negedge clk);
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("[TB] FAIL req_timeout: tx_req=%b required 1", tx_if.tx_req); end
  endtask

  task automatic check_no_req(input int cycles);
    bit seen = 0;
    for (int i = 0; i < cycles; i++) begin
      if (tx_if.tx_req !== 1'b0) seen = 1;
      @(negedge clk);
    end
    n_checks++;
    if (seen) begin n_fail++; $display("[TB] FAIL spurious_req: tx_req seen 1 required 0"); end
  endtask

  // mode 0: always ready, 1: ready 1010..., 2: random ready plus stray acks.
  task automatic receive_packet(input int mode);
    bit ok, prev_stall = 0;
    int got = 0, bubbles = 0;
    logic [7:0] prev_data = 8'h00, exp_b;
    logic prev_last = 1'b0;
    wait_req(ok);
    if (!ok) return;
    tx_if.tx_ack = 1'b1;
    @(negedge clk);
    tx_if.tx_ack = 1'b0;
    for (int cyc = 0; cyc < PKT * 20 && got < PKT; cyc++) begin
      if (prev_stall) begin
        n_checks++;
        if (tx_if.tx_valid !== 1'b1 || tx_if.tx_data !== prev_data || tx_if.tx_last !== prev_last) begin
          n_fail++;
          $display("[TB] FAIL stall_hold: valid=%b data=%02h last=%b required 1 %02h %b",
                   tx_if.tx_valid, tx_if.tx_data, tx_if.tx_last, prev_data, prev_last);
        end
      end
      if (tx_if.tx_valid !== 1'b1) bubbles++;
      case (mode)
        0:       tx_if.tx_ready = 1'b1;
        1:       tx_if.tx_ready = (cyc % 2 == 0);
        default: tx_if.tx_ready = 1'($urandom_range(0, 1));
      endcase
      tx_if.tx_ack = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (tx_if.tx_valid === 1'b1 && tx_if.tx_ready) begin
        exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        n_checks++;
        if (tx_if.tx_data !== exp_b) begin
          n_fail++;
          $display("[TB] FAIL byte_data[%0d]: got %02h required %02h", got, tx_if.tx_data, exp_b);
        end
        n_checks++;
        if (tx_if.tx_last !== (got == PKT - 1)) begin
          n_fail++;
          $display("[TB] FAIL byte_last[%0d]: got %b required %b", got, tx_if.tx_last, got == PKT - 1);
        end
        got++;
      end
      prev_stall = (tx_if.tx_valid === 1'b1) && !tx_if.tx_ready;
      prev_data  = tx_if.tx_data;
      prev_last  = tx_if.tx_last;
      @(negedge clk);
    end
    tx_if.tx_ack = 1'b0;
    tx_if.tx_ready = 1'b0;
    n_checks++;
    if (got != PKT) begin n_fail++; $display("[TB] FAIL packet_len: got %0d bytes required %0d", got, PKT); end
    n_checks++;
    if (bubbles > 1) begin n_fail++; $display("[TB] FAIL bubbles: got %0d required <=1", bubbles); end
    m_pending--;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tx_if.tx_ack = 1'b0; tx_if.tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (tx_if.tx_req   !== 1'b0)  begin n_fail++; $display("[TB] FAIL rst_req: got %b required 0", tx_if.tx_req); end
    n_checks++; if (tx_if.tx_valid !== 1'b0)  begin n_fail++; $display("[TB] FAIL rst_valid: got %b required 0", tx_if.tx_valid); end
    n_checks++; if (tx_if.tx_last  !== 1'b0)  begin n_fail++; $display("[TB] FAIL rst_last: got %b required 0", tx_if.tx_last); end
    n_checks++; if (tx_if.tx_data  !== 8'h00) begin n_fail++; $display("[TB] FAIL rst_data: got %02h required 00", tx_if.tx_data); end
    n_checks++; if (drop_cnt       !== 8'h00) begin n_fail++; $display("[TB] FAIL rst_drop: got %02h required 00", drop_cnt); end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_single_line();
    do_reset();
    send_line(1'b0, 8'h10);
    end_stream();
    receive_packet(0);
  endtask

  task automatic test_stalls();
    do_reset();
    send_line(1'b0, 8'h10);
    end_stream();
    receive_packet(1);
    send_line(1'b1, 8'h00);
    end_stream();
    receive_packet(2);
  endtask

  task automatic test_drop();
    do_reset();
    for (int l = 0; l < 3; l++) send_line(1'b1, 8'h00);
    end_stream();
    n_checks++;
    if (drop_cnt !== 8'(m_drops)) begin n_fail++; $display("[TB] FAIL drop_cnt: got %0d required %0d", drop_cnt, m_drops); end
    receive_packet(2);
    receive_packet(0);
    check_no_req(12);
  endtask

  task automatic test_drop_saturation();
    do_reset();
    for (int l = 0; l < 260; l++) send_line(1'b1, 8'h00);
    end_stream();
    n_checks++;
    if (drop_cnt !== 8'(m_drops)) begin n_fail++; $display("[TB] FAIL drop_sat: got %0d required %0d", drop_cnt, m_drops); end
    receive_packet(2);
    receive_packet(2);
  endtask

  task automatic test_frame_wrap();
    do_reset();
    for (int l = 0; l < H + 1; l++) begin
      send_line(1'b1, 8'h00);
      end_stream();
      receive_packet(l % 3);
    end
  endtask

  task automatic test_frame_sync();
    do_reset();
    send_line(1'b1, 8'h00);
    end_stream();
    receive_packet(0);
    for (int i = 0; i < 3; i++) send_pixel(8'($urandom), 1'b0);
    end_stream();
    @(negedge clk);
    frame_sync = 1'b1;
    model_sync();
    end_stream();
    send_line(1'b1, 8'h00);
    end_stream();
    receive_packet(2);
    for (int i = 0; i < 2; i++) send_pixel(8'($urandom), 1'b0);
    send_pixel(8'($urandom), 1'b1);
    for (int i = 1; i < W; i++) send_pixel(8'($urandom), 1'b0);
    end_stream();
    receive_packet(0);
    check_no_req(12);
  endtask

  task automatic test_reset_mid_packet();
    bit ok;
    do_reset();
    for (int l = 0; l < 3; l++) send_line(1'b1, 8'h00);
    end_stream();
    n_checks++;
    if (drop_cnt !== 8'(m_drops)) begin n_fail++; $display("[TB] FAIL pre_rst_drop: got %0d required %0d", drop_cnt, m_drops); end
    wait_req(ok);
    tx_if.tx_ack = 1'b1;
    @(negedge clk);
    tx_if.tx_ack = 1'b0;
    tx_if.tx_ready = 1'b1;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++; if (tx_if.tx_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_rst_valid: got %b required 0", tx_if.tx_valid); end
    n_checks++; if (tx_if.tx_req   !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_rst_req: got %b required 0", tx_if.tx_req); end
    n_checks++; if (drop_cnt       !== 8'h00) begin n_fail++; $display("[TB] FAIL mid_rst_drop: got %02h required 00", drop_cnt); end
    tx_if.tx_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    send_line(1'b1, 8'h00);
    end_stream();
    receive_packet(0);
  endtask

  initial begin
    tx_if.tx_ack = 1'b0;
    tx_if.tx_ready = 1'b0;
    test_reset();
    test_single_line();
    test_stalls();
    test_drop();
    test_drop_saturation();
    test_frame_wrap();
    test_frame_sync();
    test_reset_mid_packet();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
